// File: rtl/obj_position_ctrl.sv
// Horizontal position, motion and graphics-mask controller for one object.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | position holds; an HMOVE strobe may start a motion
//  MOVE  | one pixel step per clock until the latched step count runs out
module obj_position_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pixelNum,
   input  logic       resStrobe,
   input  logic       hmWe,
   input  logic [3:0] hmData,
   input  logic       hmClr,
   input  logic       hmoveStrobe,
   input  logic       grWe,
   input  logic [7:0] grData,
   input  logic       grOtherWe,
   input  logic       vdel,
   input  logic       reflect,
   output logic [7:0] objPos,
   output logic [7:0] objMask,
   output logic       hmoveBusy
);

   localparam logic [7:0] LAST_PIX = 8'd159;

   typedef enum logic {IDLE, MOVE} state_t;

   state_t     state_q, state_d;
   logic [7:0] pos_q, pos_d;
   logic [3:0] hm_q, hm_d;
   logic [7:0] gr_new_q, gr_new_d;
   logic [7:0] gr_old_q, gr_old_d;
   logic [3:0] step_cnt_q, step_cnt_d;
   logic       dir_left_q, dir_left_d;

   logic [3:0] hm_abs;
   logic [7:0] pos_step;
   logic [7:0] gr_sel;

   // Magnitude of the signed motion value; -8 maps to 8, which still fits in 4 bits.
   assign hm_abs = hm_q[3] ? (~hm_q + 4'd1) : hm_q;

   // One-pixel step with wrap so the position never leaves the visible range.
   always_comb begin
      pos_step = pos_q;
      if (dir_left_q) begin
         pos_step = (pos_q == 8'd0) ? LAST_PIX : pos_q - 8'd1;
      end else begin
         pos_step = (pos_q == LAST_PIX) ? 8'd0 : pos_q + 8'd1;
      end
   end

   // State register and all datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pos_q      <= 8'd0;
         hm_q       <= 4'd0;
         gr_new_q   <= 8'd0;
         gr_old_q   <= 8'd0;
         step_cnt_q <= 4'd0;
         dir_left_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         hm_q       <= hm_d;
         gr_new_q   <= gr_new_d;
         gr_old_q   <= gr_old_d;
         step_cnt_q <= step_cnt_d;
         dir_left_q <= dir_left_d;
      end
   end

   // Next-state logic: position reset outranks any motion, motion register is independent.
   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      hm_d       = hm_q;
      gr_new_d   = gr_new_q;
      gr_old_d   = gr_old_q;
      step_cnt_d = step_cnt_q;
      dir_left_d = dir_left_q;

      if (hmClr) begin
         hm_d = 4'd0;
      end else if (hmWe) begin
         hm_d = hmData;
      end

      if (grWe) begin
         gr_new_d = grData;
      end
      if (grOtherWe) begin
         gr_old_d = gr_new_q;
      end

      if (resStrobe) begin
         pos_d      = (pixelNum <= LAST_PIX) ? pixelNum : 8'd0;
         step_cnt_d = 4'd0;
         state_d    = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (hmoveStrobe) begin
                  step_cnt_d = hm_abs;
                  dir_left_d = ~hm_q[3] && (hm_q != 4'd0);
                  if (hm_abs != 4'd0) begin
                     state_d = MOVE;
                  end
               end
            end
            MOVE: begin
               pos_d      = pos_step;
               step_cnt_d = step_cnt_q - 4'd1;
               if (step_cnt_q == 4'd1) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Graphics select and optional reversal; bit 0 of the mask is drawn first.
   always_comb begin
      gr_sel  = vdel ? gr_old_q : gr_new_q;
      objMask = gr_sel;
      if (!reflect) begin
         for (int i = 0; i < 8; i++) begin
            objMask[i] = gr_sel[7-i];
         end
      end
   end

   assign objPos    = pos_q;
   assign hmoveBusy = (state_q == MOVE);

endmodule

// File: tb/tb_obj_position_ctrl.sv
// Self-checking bench for obj_position_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_obj_position_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] pixelNum = 8'd0;
   logic       resStrobe = 1'b0;
   logic       hmWe = 1'b0;
   logic [3:0] hmData = 4'd0;
   logic       hmClr = 1'b0;
   logic       hmoveStrobe = 1'b0;
   logic       grWe = 1'b0;
   logic [7:0] grData = 8'd0;
   logic       grOtherWe = 1'b0;
   logic       vdel = 1'b0;
   logic       reflect = 1'b0;
   logic [7:0] objPos;
   logic [7:0] objMask;
   logic       hmoveBusy;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // behavioural model state
   int         m_pos;
   int         m_hm;
   int         m_rem;
   bit         m_left;
   logic [7:0] m_new;
   logic [7:0] m_old;

   obj_position_ctrl dut (
      .clk(clk), .reset(reset), .pixelNum(pixelNum), .resStrobe(resStrobe),
      .hmWe(hmWe), .hmData(hmData), .hmClr(hmClr), .hmoveStrobe(hmoveStrobe),
      .grWe(grWe), .grData(grData), .grOtherWe(grOtherWe), .vdel(vdel),
      .reflect(reflect), .objPos(objPos), .objMask(objMask), .hmoveBusy(hmoveBusy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_mask();
      logic [7:0] sel;
      logic [7:0] m;
      sel = vdel ? m_old : m_new;
      if (reflect) return sel;
      for (int i = 0; i < 8; i++) m[i] = sel[7-i];
      return m;
   endfunction

   task automatic model_reset();
      m_pos = 0; m_hm = 0; m_rem = 0; m_left = 0; m_new = 8'd0; m_old = 8'd0;
   endtask

   // Advance the model by one clock using the inputs held before the edge.
   task automatic model_update();
      int mag;
      if (reset) begin
         model_reset();
         return;
      end
      if (resStrobe) begin
         m_pos = (pixelNum < 160) ? int'(pixelNum) : 0;
         m_rem = 0;
      end else if (m_rem > 0) begin
         m_pos = m_left ? (m_pos + 159) % 160 : (m_pos + 1) % 160;
         m_rem--;
      end else if (hmoveStrobe) begin
         mag    = (m_hm < 0) ? -m_hm : m_hm;
         m_rem  = mag;
         m_left = (m_hm > 0);
      end
      if (hmClr) m_hm = 0;
      else if (hmWe) m_hm = (hmData >= 8) ? int'(hmData) - 16 : int'(hmData);
      if (grOtherWe) m_old = m_new;
      if (grWe) m_new = grData;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_in();
      resStrobe = 0; hmWe = 0; hmClr = 0; hmoveStrobe = 0; grWe = 0; grOtherWe = 0;
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pos_model",  int'(objPos),    m_pos);
         chk("mask_model", int'(objMask),   int'(model_mask()));
         chk("busy_model", int'(hmoveBusy), int'(m_rem > 0));
      end
   end

   initial begin
      int exp39 [5];
      model_reset();
      #1 reset = 1'b1;
      chk_en = 1'b1;
      step(); step();
      chk("reset_pos",  int'(objPos), 0);
      chk("reset_mask", int'(objMask), 0);
      chk("reset_busy", int'(hmoveBusy), 0);
      reset = 1'b0;
      step();

      // position reset inside and outside the visible range
      resStrobe = 1; pixelNum = 8'd42; step(); clear_in();
      chk("res_42", int'(objPos), 42);
      resStrobe = 1; pixelNum = 8'd200; step(); clear_in();
      chk("res_200", int'(objPos), 0);

      // +5 motion from 3 wraps left through 0
      resStrobe = 1; pixelNum = 8'd3; step(); clear_in();
      hmWe = 1; hmData = 4'h5; step(); clear_in();
      hmoveStrobe = 1; step(); clear_in();
      chk("m5_busy_start", int'(hmoveBusy), 1);
      chk("m5_pos_start", int'(objPos), 3);
      exp39 = '{2, 1, 0, 159, 158};
      for (int i = 0; i < 5; i++) begin
         step();
         chk("m5_pos", int'(objPos), exp39[i]);
         chk("m5_busy", int'(hmoveBusy), (i < 4) ? 1 : 0);
      end
      step();
      chk("m5_idle_pos", int'(objPos), 158);

      // -8 motion from 158 wraps right; a second strobe mid-move is ignored
      hmWe = 1; hmData = 4'h8; step(); clear_in();
      hmoveStrobe = 1; step(); clear_in();
      for (int i = 1; i <= 8; i++) begin
         if (i == 3) hmoveStrobe = 1;
         step();
         hmoveStrobe = 0;
         if (i == 7) chk("m8_busy7", int'(hmoveBusy), 1);
      end
      chk("m8_pos", int'(objPos), 6);
      chk("m8_busy_end", int'(hmoveBusy), 0);
      step(); step();
      chk("m8_pos_hold", int'(objPos), 6);

      // position reset aborts a motion in progress
      hmoveStrobe = 1; step(); clear_in();
      step(); step();
      resStrobe = 1; pixelNum = 8'd80; step(); clear_in();
      chk("abort_pos", int'(objPos), 80);
      chk("abort_busy", int'(hmoveBusy), 0);
      step(); step(); step();
      chk("abort_hold", int'(objPos), 80);

      // graphics delay copy, select and reflect
      grWe = 1; grData = 8'hC1; step(); clear_in();
      grOtherWe = 1; step(); clear_in();
      grWe = 1; grData = 8'h0F; step(); clear_in();
      vdel = 1; reflect = 0; #1;
      chk("mask_vdel1", int'(objMask), 'h83);
      vdel = 0; #1;
      chk("mask_vdel0", int'(objMask), 'hF0);
      reflect = 1; #1;
      chk("mask_refl", int'(objMask), 'h0F);

      // same-cycle graphics write and copy
      grWe = 1; grData = 8'h55; step(); clear_in();
      grWe = 1; grData = 8'hAA; grOtherWe = 1; step(); clear_in();
      vdel = 1; reflect = 1; #1;
      chk("same_old", int'(objMask), 'h55);
      vdel = 0; #1;
      chk("same_new", int'(objMask), 'hAA);

      // asynchronous reset mid-motion, checked before any clock edge
      hmoveStrobe = 1; step(); clear_in();
      #1 reset = 1'b1;
      model_reset();
      #1;
      chk("arst_pos",  int'(objPos), 0);
      chk("arst_mask", int'(objMask), 0);
      chk("arst_busy", int'(hmoveBusy), 0);
      step(); step();
      reset = 1'b0;
      step();

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         pixelNum    = 8'($urandom_range(0, 255));
         resStrobe   = ($urandom_range(0, 15) == 0);
         hmWe        = ($urandom_range(0, 5) == 0);
         hmData      = 4'($urandom_range(0, 15));
         hmClr       = ($urandom_range(0, 15) == 0);
         hmoveStrobe = ($urandom_range(0, 4) == 0);
         grWe        = ($urandom_range(0, 3) == 0);
         grData      = 8'($urandom_range(0, 255));
         grOtherWe   = ($urandom_range(0, 3) == 0);
         vdel        = 1'($urandom_range(0, 1));
         reflect     = 1'($urandom_range(0, 1));
         step();
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/obj_position_ctrl.md
OBJ_POSITION_CTRL -- requirements
Module: obj_position_ctrl

Interface
REQ-001 SHALL have no parameters; screen width is fixed at 160 pixels (positions 0..159).
REQ-002 clk  input  1  colour clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pixelNum  input  8  current beam pixel; 0..159 visible, any value >=160 means horizontal blank.
REQ-005 resStrobe  input  1  one-cycle strobe that resets the object position (RESPx write).
REQ-006 hmWe  input  1  write strobe for the motion register.
REQ-007 hmData  input  4  signed two's-complement motion value, -8..+7; positive moves left.
REQ-008 hmClr  input  1  strobe that clears the motion register to 0.
REQ-009 hmoveStrobe  input  1  strobe that starts applying the motion register (HMOVE).
REQ-010 grWe  input  8-bit-data strobe  1  write strobe for this object's graphics register.
REQ-011 grData  input  8  graphics byte; bit 7 is the leftmost pixel when not reflected.
REQ-012 grOtherWe  input  1  write strobe of the partner object's graphics register; copies new graphics to the delayed copy.
REQ-013 vdel  input  1  selects delayed graphics copy when 1.
REQ-014 reflect  input  1  horizontal reflect of graphics when 1.
REQ-015 objPos  output  8  object position, always 0..159; feeds the pixel-on stage.
REQ-016 objMask  output  8  pixel mask; bit 0 is the first drawn pixel.
REQ-017 hmoveBusy  output  1  high while a motion is being applied.

Function
REQ-018 SHALL hold registers: pos[7:0], hm[3:0], grNew[7:0], grOld[7:0], state (IDLE/MOVE), stepCnt[3:0], dirLeft.
REQ-019 On resStrobe: pos <= pixelNum if pixelNum<=159, else pos <= 0; visible on objPos the next cycle.
REQ-020 On hmWe: hm <= hmData; on hmClr: hm <= 0; hmClr wins when both are asserted in the same cycle.
REQ-021 IDLE + hmoveStrobe: stepCnt <= |hm| (0..8), dirLeft <= (hm>0); go to MOVE if |hm|!=0, otherwise stay in IDLE.
REQ-022 MOVE: each cycle pos moves one pixel (left: pos-1, right: pos+1) and stepCnt decrements; return to IDLE in the cycle in which stepCnt reaches 0.
REQ-023 Latency: a motion of magnitude N completes N cycles after the hmoveStrobe edge; hmoveBusy = (state==MOVE).
REQ-024 Wrap: left step from 0 gives 159; right step from 159 gives 0; pos never leaves 0..159.
REQ-025 hmoveStrobe during MOVE SHALL be ignored.
REQ-026 hmWe or hmClr during MOVE SHALL update hm but not the motion in progress.
REQ-027 resStrobe during MOVE SHALL take priority: pos loads per REQ-019, the motion is aborted, and the state returns to IDLE in the same edge.
REQ-028 resStrobe together with hmoveStrobe in IDLE: the position reset applies and the motion start is ignored.
REQ-029 On grWe: grNew <= grData.
REQ-030 On grOtherWe: grOld <= grNew (pre-edge value of grNew).
REQ-031 When grWe and grOtherWe occur in the same cycle: grOld gets the old grNew and grNew gets grData.
REQ-032 sel = vdel ? grOld : grNew.
REQ-033 objMask = reflect ? sel : bit-reverse(sel); this path is combinational from registers and mode inputs.
REQ-034 objPos SHALL be driven directly from pos (registered, glitch-free).

Reset
REQ-035 Asynchronous reset SHALL clear pos, hm, grNew, grOld, and stepCnt to 0, clear dirLeft, and set state to IDLE.
REQ-036 During and immediately after reset: objPos=0, objMask=0, and hmoveBusy=0.
REQ-037 Reset asserted mid-MOVE SHALL abort the motion immediately without waiting for a clock edge.

Verification
REQ-038 resStrobe with pixelNum=42 -> objPos=42 next cycle; resStrobe with pixelNum=200 -> objPos=0.
REQ-039 pos=3, hmWe hmData=4'h5, hmoveStrobe -> hmoveBusy high 5 cycles; objPos 2,1,0,159,158; then idle at 158.
REQ-040 pos=158, hmData=4'h8 (-8), hmoveStrobe -> objPos reaches 6 after 8 cycles; a second hmoveStrobe at cycle 3 has no effect.
REQ-041 During MOVE, resStrobe with pixelNum=80 -> objPos=80 next cycle; hmoveBusy=0; no further steps.
REQ-042 grWe 8'hC1, then grOtherWe, then grWe 8'h0F, vdel=1 -> objMask=8'h83; with vdel=0 -> 8'hF0; with vdel=0, reflect=1 -> 8'h0F.
REQ-043 Same-cycle grWe 8'hAA and grOtherWe with grNew=8'h55 -> grOld=8'h55 and grNew=8'hAA; async reset mid-sequence -> all outputs 0 without a clock.
